// File: rtl/divmult_ctrl.sv
// Sequencer for the DIVMULT unit and the HI/LO register pair.
// Optional zero-operand early-out: define DIVMULT_FASTZERO_EN.
module divmult_ctrl #(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_div,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        op_ready,
  output logic [31:0] dm_a,
  output logic [31:0] dm_b,
  output logic        dm_mdcontrol,
  output logic        dm_start,
  input  logic        dm_div0,
  output logic        hilo_load,
  output logic        hilo_zero,
  input  logic        rd_hilo,
  output logic        stall,
  output logic        done,
  output logic        div0_exc
);

  localparam logic [5:0] MULT_N = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_N  = 6'(DIV_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_EXC
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        mdc_q, mdc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        zero_q, zero_d;
  logic        fast_zero;

`ifdef DIVMULT_FASTZERO_EN
  assign fast_zero = mdc_q ? ((a_q == '0) && (b_q != '0))
                           : ((a_q == '0) || (b_q == '0));
`else
  assign fast_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mdc_q   <= 1'b0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mdc_q   <= mdc_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mdc_d     = mdc_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    dm_start  = 1'b0;
    hilo_load = 1'b0;
    hilo_zero = 1'b0;
    done      = 1'b0;
    div0_exc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          mdc_d   = op_div;
          zero_d  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mdc_q && (b_q == '0)) begin
          state_d = S_EXC;
        end else if (fast_zero) begin
          zero_d  = 1'b1;
          state_d = S_WRITE;
        end else begin
          dm_start = 1'b1;
          cnt_d    = mdc_q ? DIV_N : MULT_N;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 6'd1;
        if (dm_div0) begin
          state_d = S_EXC;
        end else if (cnt_q == 6'd1) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        hilo_load = 1'b1;
        hilo_zero = zero_q;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      S_EXC: begin
        div0_exc = 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A cycle with reset low must not commit HI/LO or signal completion.
    if (!reset) begin
      dm_start  = 1'b0;
      hilo_load = 1'b0;
      hilo_zero = 1'b0;
      done      = 1'b0;
      div0_exc  = 1'b0;
    end
  end

  assign op_ready     = (state_q == S_IDLE);
  assign stall        = (state_q != S_IDLE) && (op_valid || rd_hilo);
  assign dm_a         = a_q;
  assign dm_b         = b_q;
  assign dm_mdcontrol = mdc_q;

endmodule

// File: tb/tb_divmult_ctrl.sv
// Self-checking bench for divmult_ctrl with a behavioural DIVMULT and HI/LO pair.
module tb_divmult_ctrl;

  localparam int MC = 32;
  localparam int DC = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_div = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        op_ready;
  logic [31:0] dm_a, dm_b;
  logic        dm_mdcontrol, dm_start;
  logic        dm_div0 = 1'b0;
  logic        hilo_load, hilo_zero;
  logic        rd_hilo = 1'b0;
  logic        stall, done, div0_exc;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] hi_r = '0, lo_r = '0;
  logic [63:0] res_r = '0;
  logic [31:0] nxt_a, nxt_b;
  logic        nxt_div;

  divmult_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_div(op_div),
    .a_in(a_in), .b_in(b_in), .op_ready(op_ready), .dm_a(dm_a), .dm_b(dm_b),
    .dm_mdcontrol(dm_mdcontrol), .dm_start(dm_start), .dm_div0(dm_div0),
    .hilo_load(hilo_load), .hilo_zero(hilo_zero), .rd_hilo(rd_hilo),
    .stall(stall), .done(done), .div0_exc(div0_exc)
  );

  always #5 clk = ~clk;

  // Signed MIPS-style result: {HI,LO} = product, or {remainder, quotient}.
  function automatic logic [63:0] arith(input logic [31:0] a, input logic [31:0] b,
                                        input logic div);
    logic signed [63:0] sa, sb;
    logic signed [31:0] a32, b32, q, r;
    if (!div) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
    end
    if (b == '0) return '0;
    a32 = a;
    b32 = b;
    q = a32 / b32;
    r = a32 % b32;
    return {r, q};
  endfunction

  // External DIVMULT unit and HI/LO registers driven by the controller.
  always @(posedge clk) begin
    if (dm_start === 1'b1) res_r <= arith(dm_a, dm_b, dm_mdcontrol);
    if (hilo_load === 1'b1) begin
      hi_r <= (hilo_zero === 1'b1) ? '0 : res_r[63:32];
      lo_r <= (hilo_zero === 1'b1) ? '0 : res_r[31:0];
    end
  end

  task automatic test_reset;
    logic [6:0] act;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    act = {op_ready, dm_start, hilo_load, hilo_zero, stall, done, div0_exc};
    vectors++;
    if (act !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_outputs got %b exp %b", act, 7'b1000000);
    end
    vectors++;
    if ({dm_a, dm_b, dm_mdcontrol} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_operands got %h/%h/%b exp 0", dm_a, dm_b, dm_mdcontrol);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One operation from acceptance to the following IDLE cycle; t counts cycles
  // after the accepting edge. Optionally holds rd_hilo, raises a second request
  // (operands nxt_*), or injects dm_div0 during WAIT.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic div,
                        input int hold_rd, input int second_at, input int div0_at,
                        output logic chained);
    int n, end_t;
    logic exc_zero, fast, inj, exc;
    logic [63:0] exp_hl;
    logic [6:0] act, expv;
    logic in_op;
    n = div ? DC : MC;
    exc_zero = div && (b == '0);
`ifdef DIVMULT_FASTZERO_EN
    fast = div ? ((a == '0) && (b != '0)) : ((a == '0) || (b == '0));
`else
    fast = 1'b0;
`endif
    inj = !exc_zero && !fast && (div0_at >= 2) && (div0_at <= n + 1);
    exc = exc_zero || inj;
    end_t = (exc_zero || fast) ? 2 : (inj ? div0_at + 1 : n + 2);
    chained = (second_at >= 1) && (second_at <= end_t + 1);
    exp_hl = exc ? {hi_r, lo_r} : (fast ? 64'd0 : arith(a, b, div));

    op_valid = 1'b1; a_in = a; b_in = b; op_div = div;
    rd_hilo = (hold_rd == 0); dm_div0 = 1'b0;
    #1;
    act = {op_ready, dm_start, hilo_load, hilo_zero, stall, done, div0_exc};
    vectors++;
    if (act !== 7'b1000000) begin
      miscompares++;
      $display("FAIL accept_idle got %b exp %b", act, 7'b1000000);
    end
    for (int t = 1; t <= end_t + 1; t++) begin
      @(posedge clk);
      #1;
      op_valid = chained && (t >= second_at);
      if (op_valid) begin a_in = nxt_a; b_in = nxt_b; op_div = nxt_div; end
      rd_hilo = (hold_rd >= 0) && (t >= hold_rd);
      dm_div0 = inj && (t == div0_at);
      #1;
      in_op = (t <= end_t);
      expv = {!in_op, (t == 1) && !exc_zero && !fast, (t == end_t) && !exc,
              (t == end_t) && !exc && fast, in_op && (op_valid || rd_hilo),
              t == end_t, (t == end_t) && exc};
      act = {op_ready, dm_start, hilo_load, hilo_zero, stall, done, div0_exc};
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL ctrl t=%0d a=%h b=%h div=%b got %b exp %b", t, a, b, div, act, expv);
      end
      vectors++;
      if ({dm_a, dm_b, dm_mdcontrol} !== {a, b, div}) begin
        miscompares++;
        $display("FAIL operands t=%0d got %h/%h/%b exp %h/%h/%b",
                 t, dm_a, dm_b, dm_mdcontrol, a, b, div);
      end
      if (t == end_t + 1) begin
        vectors++;
        if ({hi_r, lo_r} !== exp_hl) begin
          miscompares++;
          $display("FAIL hilo a=%h b=%h div=%b got %h exp %h", a, b, div, {hi_r, lo_r}, exp_hl);
        end
      end
    end
    rd_hilo = 1'b0;
    dm_div0 = 1'b0;
  endtask

  task automatic test_mult_basic;
    logic ch;
    run_op(32'd7, 32'hFFFF_FFFD, 1'b0, 1, -1, -1, ch);
  endtask

  task automatic test_div_basic;
    logic ch;
    run_op(32'd100, 32'd7, 1'b1, -1, -1, -1, ch);
  endtask

  task automatic test_div_zero;
    logic ch;
    run_op(32'd5, 32'd0, 1'b1, 2, -1, -1, ch);
  endtask

  task automatic test_reset_mid;
    logic [6:0] act, expv;
    logic [63:0] old_hl;
    logic ch;
    old_hl = {hi_r, lo_r};
    op_valid = 1'b1; a_in = 32'd9; b_in = 32'd11; op_div = 1'b0;
    for (int t = 1; t <= 45; t++) begin
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      reset = (t != 10);
      #1;
      expv = {t >= 11, t == 1, 5'b00000};
      act = {op_ready, dm_start, hilo_load, hilo_zero, stall, done, div0_exc};
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL reset_mid t=%0d got %b exp %b", t, act, expv);
      end
    end
    vectors++;
    if ({hi_r, lo_r} !== old_hl) begin
      miscompares++;
      $display("FAIL reset_mid_hilo got %h exp %h", {hi_r, lo_r}, old_hl);
    end
    run_op(32'hFFFF_FFFE, 32'd50, 1'b0, -1, -1, -1, ch);
  endtask

  task automatic test_back_to_back;
    logic ch;
    nxt_a = 32'd1000; nxt_b = 32'hFFFF_FFF6; nxt_div = 1'b1;
    run_op(32'd3, 32'd4, 1'b0, 5, 10, -1, ch);
    vectors++;
    if (ch !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back_chain got %b exp 1", ch);
    end
    run_op(nxt_a, nxt_b, nxt_div, -1, -1, -1, ch);
  endtask

  task automatic test_fastzero;
    logic ch;
    run_op(32'd0, 32'd123, 1'b0, -1, -1, -1, ch);
    run_op(32'd0, 32'd17, 1'b1, -1, -1, -1, ch);
  endtask

  task automatic test_div0_flag;
    logic ch;
    run_op(32'd77, 32'd3, 1'b1, 1, -1, int'($urandom_range(2, DC + 1)), ch);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic div, ch;
    int hold_rd, second_at, div0_at;
    ch = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (ch) begin
        a = nxt_a; b = nxt_b; div = nxt_div;
      end else begin
        a = $urandom; b = $urandom; div = 1'($urandom);
        if ($urandom_range(0, 3) == 0) a = '0;
        if ($urandom_range(0, 3) == 0) b = '0;
      end
      if (div && (b == 32'hFFFF_FFFF)) b = 32'd1;
      hold_rd   = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 40));
      second_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1;
      div0_at   = (div && $urandom_range(0, 3) == 0) ? int'($urandom_range(2, 34)) : -1;
      nxt_a = $urandom; nxt_b = $urandom; nxt_div = 1'($urandom);
      if (nxt_div && (nxt_b == 32'hFFFF_FFFF)) nxt_b = 32'd2;
      run_op(a, b, div, hold_rd, second_at, div0_at, ch);
    end
    if (ch) run_op(nxt_a, nxt_b, nxt_div, -1, -1, -1, ch);
    op_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_mult_basic;
    test_div_basic;
    test_div_zero;
    test_reset_mid;
    test_back_to_back;
    test_fastzero;
    test_div0_flag;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divmult_ctrl.md
Name: divmult_ctrl

Overview:
- Sequencer for the multiply/divide unit (DIVMULT) and its HI/LO register pair.
- Accepts MULT/DIV requests from the main control unit and latches the operands.
- Pulses start on the unit, counts its fixed latency, then loads HI/LO.
- Raises a divide-by-zero exception, and stalls the pipeline on new requests or HI/LO reads while an operation is in flight.

Parameters:
- MULT_CYCLES, 32: cycles DIVMULT needs for a multiply after start (range 1..63).
- DIV_CYCLES, 32: cycles DIVMULT needs for a divide after start (range 1..63).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- op_valid  in  1  MULT/DIV request; held by the requester until accepted.
- op_div  in  1  1=DIV (signed A/B), 0=MULT (signed A*B).
- a_in  in  32  operand A.
- b_in  in  32  operand B.
- op_ready  out  1  high only in IDLE.
- dm_a  out  32  latched A to DIVMULT.
- dm_b  out  32  latched B to DIVMULT.
- dm_mdcontrol  out  1  latched op_div to DIVMULT.
- dm_start  out  1  one-cycle start pulse to DIVMULT.
- dm_div0  in  1  div0 flag from DIVMULT.
- hilo_load  out  1  load enable for the HI and LO registers.
- hilo_zero  out  1  forces the HI/LO register inputs to 0 while hilo_load=1.
- rd_hilo  in  1  an MFHI/MFLO is in the decode stage.
- stall  out  1  pipeline stall.
- done  out  1  one-cycle completion pulse.
- div0_exc  out  1  one-cycle divide-by-zero exception pulse.

Behaviour:
- Reset value of every output is 0, except op_ready=1 (state IDLE). Reset also clears the latched operands and the counter.
- States and transitions:
  - IDLE: if op_valid=1, latch a_in/b_in/op_div into dm_a/dm_b/dm_mdcontrol, go to ISSUE.
  - ISSUE: if op_div=1 and dm_b==0, go to EXC and do not assert dm_start. Otherwise assert dm_start=1, load the counter with MULT_CYCLES or DIV_CYCLES, go to WAIT.
  - WAIT: decrement the counter each cycle. Go to WRITE after exactly N cycles (N = the selected parameter). If dm_div0=1 in any WAIT cycle, go to EXC immediately.
  - WRITE: assert hilo_load=1 and done=1, go to IDLE.
  - EXC: assert div0_exc=1 and done=1, keep hilo_load=0 so HI/LO are unchanged, go to IDLE.
- Latency: if op_valid is sampled in IDLE at edge k, then ISSUE is cycle k+1, WAIT is cycles k+2..k+N+1, and hilo_load is high in cycle k+N+2. HI/LO hold the new value from edge k+N+3. With defaults this is k+34.
- dm_a, dm_b and dm_mdcontrol stay constant from ISSUE through WRITE/EXC.
- stall = (state != IDLE) & (op_valid | rd_hilo). stall is still asserted in WRITE, because HI/LO are not yet updated.
- In IDLE, rd_hilo and op_valid never stall.
- Simultaneous op_valid and rd_hilo in IDLE: the op is accepted and the read proceeds with the old HI/LO.
- op_valid outside IDLE is ignored (stalled) and is not queued.
- Back-to-back ops: a new op can be accepted in the IDLE cycle right after WRITE/EXC, giving a minimum spacing of N+3 cycles.
- Reset low mid-operation (any state): next state is IDLE, no hilo_load, no done, and no exception. HI/LO keep whatever their own registers hold.
- Counter is 6 bits. A parameter value of 0 is illegal.

Optional Feature:
- Macro DIVMULT_FASTZERO_EN.
- When defined, the early-out check happens in ISSUE. A MULT with dm_a==0 or dm_b==0, or a DIV with dm_a==0 and dm_b!=0, skips dm_start and WAIT and goes straight to WRITE with hilo_zero=1. Latency is then 3 cycles (hilo_load in cycle k+2).
- When not defined, hilo_zero is tied 0 and every op takes the full N-cycle path.

Test Plan:
- Reset, then MULT a_in=7, b_in=-3, defaults: dm_start pulses at k+1; hilo_load and done at k+34; HI=0xFFFFFFFF, LO=0xFFFFFFEB; stall only during k+1..k+34 while op_valid or rd_hilo is held.
- DIV a_in=100, b_in=7: hilo_load at k+34; LO=14, HI=2; op_ready back to 1 at k+35.
- DIV a_in=5, b_in=0: no dm_start; div0_exc and done in cycle k+2; hilo_load stays 0; HI/LO keep their prior values.
- MULT accepted, reset driven low at k+10 for 1 cycle: IDLE at k+11; no hilo_load, no done, no div0_exc afterwards; a new op is accepted normally.
- rd_hilo held from k+5: stall=1 through k+34 and 0 at k+35. A second op_valid during WAIT is not accepted until IDLE.
- With DIVMULT_FASTZERO_EN, MULT a_in=0, b_in=123: hilo_load=1 and hilo_zero=1 at k+2, dm_start never pulses, HI=LO=0. Without the macro, the same stimulus completes at k+34.
